// File: rtl/output_gather_pe.sv
// Output gather stage: accumulates PE partial sums per tile, requantises with
// shift/ReLU/saturation, then drains the results LANES elements per beat.
module output_gather_pe #(
  parameter  int NUM_PE = 16,
  parameter  int PSUM_W = 32,
  parameter  int OUT_W  = 16,
  parameter  int LANES  = 4,
  localparam int BEATS  = NUM_PE / LANES,
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_PE*PSUM_W-1:0]  pe_psum,
  input  logic                      pe_valid,
  output logic                      pe_ready,
  input  logic                      tile_first,
  input  logic                      tile_last,
  input  logic                      relu_en,
  input  logic [4:0]                out_shift,
  output logic [LANES*OUT_W-1:0]    obuf_data,
  output logic [BEAT_W-1:0]         obuf_beat,
  output logic                      obuf_valid,
  input  logic                      obuf_ready,
  output logic                      tile_done,
  output logic                      sat_flag
);

  // state | meaning
  // IDLE  | no tile open, next accept overwrites the accumulators
  // ACC   | tile open, accepts accumulate unless tile_first
  // QNT   | one cycle: requantise all accumulators into the result buffer
  // DRN   | present result beats to the output buffer
  typedef enum logic [1:0] {S_IDLE, S_ACC, S_QNT, S_DRN} state_t;

  localparam logic signed [PSUM_W-1:0] MAXV = PSUM_W'((1 << (OUT_W-1)) - 1);
  localparam logic signed [PSUM_W-1:0] MINV = ~MAXV;

  state_t state_q, state_d;

  logic signed [PSUM_W-1:0]            acc     [NUM_PE];
  logic signed [PSUM_W-1:0]            shifted [NUM_PE];
  logic        [BEATS-1:0][LANES*OUT_W-1:0] qbuf, qpack;
  logic        [BEAT_W-1:0]            beat_q;
  logic        [4:0]                   shift_r;
  logic                                relu_r;
  logic                                sat_any;
  logic                                accept;
  logic                                last_beat;
  logic                                overwrite;

  assign accept    = pe_valid & pe_ready;
  assign last_beat = (beat_q == BEAT_W'(BEATS-1));
  assign overwrite = (state_q == S_IDLE) | tile_first;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_ACC: if (accept) state_d = tile_last ? S_QNT : S_ACC;
      S_QNT:         state_d = S_DRN;
      S_DRN:         if (obuf_ready && last_beat) state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pe_ready   = (state_q == S_IDLE) || (state_q == S_ACC);
    obuf_valid = (state_q == S_DRN);
    obuf_beat  = beat_q;
    obuf_data  = '0;
    if (state_q == S_DRN) obuf_data = qbuf[beat_q];
  end

  // Floor shift, then ReLU, then clip to the signed output range.
  always_comb begin
    sat_any = 1'b0;
    qpack   = '0;
    for (int k = 0; k < NUM_PE; k++) begin
      shifted[k] = acc[k] >>> shift_r;
      if (relu_r && shifted[k][PSUM_W-1]) begin
        qpack[k/LANES][(k%LANES)*OUT_W +: OUT_W] = '0;
      end else if (shifted[k] > MAXV) begin
        qpack[k/LANES][(k%LANES)*OUT_W +: OUT_W] = MAXV[OUT_W-1:0];
        sat_any = 1'b1;
      end else if (shifted[k] < MINV) begin
        qpack[k/LANES][(k%LANES)*OUT_W +: OUT_W] = MINV[OUT_W-1:0];
        sat_any = 1'b1;
      end else begin
        qpack[k/LANES][(k%LANES)*OUT_W +: OUT_W] = shifted[k][OUT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_PE; k++) acc[k] <= '0;
      qbuf      <= '0;
      beat_q    <= '0;
      shift_r   <= '0;
      relu_r    <= 1'b0;
      sat_flag  <= 1'b0;
      tile_done <= 1'b0;
    end else begin
      tile_done <= 1'b0;
      if (accept) begin
        for (int k = 0; k < NUM_PE; k++) begin
          if (overwrite) acc[k] <= pe_psum[k*PSUM_W +: PSUM_W];
          else           acc[k] <= acc[k] + pe_psum[k*PSUM_W +: PSUM_W];
        end
        if (overwrite) sat_flag <= 1'b0;
        if (tile_last) begin
          relu_r  <= relu_en;
          shift_r <= out_shift;
        end
      end
      if (state_q == S_QNT) begin
        qbuf   <= qpack;
        beat_q <= '0;
        if (sat_any) sat_flag <= 1'b1;
      end
      if ((state_q == S_DRN) && obuf_ready) begin
        if (last_beat) begin
          beat_q    <= '0;
          tile_done <= 1'b1;
        end else begin
          beat_q <= beat_q + BEAT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_output_gather_pe.sv
// Directed bench for output_gather_pe: expected beats are queued at stimulus
// time and a negedge monitor checks every presented beat and tile_done.
module tb_output_gather_pe;

  logic         clk = 1'b0;
  logic         rst;
  logic [511:0] pe_psum;
  logic         pe_valid, pe_ready;
  logic         tile_first, tile_last, relu_en;
  logic [4:0]   out_shift;
  logic [63:0]  obuf_data;
  logic [1:0]   obuf_beat;
  logic         obuf_valid, obuf_ready;
  logic         tile_done, sat_flag;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  beat;
  } beat_t;

  beat_t exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    hs_count = 0;
  bit    prev_last = 1'b0;

  output_gather_pe dut (
    .clk(clk), .rst(rst), .pe_psum(pe_psum), .pe_valid(pe_valid),
    .pe_ready(pe_ready), .tile_first(tile_first), .tile_last(tile_last),
    .relu_en(relu_en), .out_shift(out_shift), .obuf_data(obuf_data),
    .obuf_beat(obuf_beat), .obuf_valid(obuf_valid), .obuf_ready(obuf_ready),
    .tile_done(tile_done), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_last = 1'b0;
    end else begin
      check("tile_done", {63'd0, tile_done}, {63'd0, prev_last});
      prev_last = 1'b0;
      if (obuf_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {62'd0, obuf_beat}, 64'hDEAD);
        end else begin
          check("obuf_data", obuf_data, exp_q[0].data);
          check("obuf_beat", {62'd0, obuf_beat}, {62'd0, exp_q[0].beat});
          if (obuf_ready) begin
            if (exp_q[0].beat == 2'd3) prev_last = 1'b1;
            void'(exp_q.pop_front());
            hs_count++;
          end
        end
      end
    end
  end

  function automatic logic [511:0] uniform_psum(input logic [31:0] v);
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = v;
    return r;
  endfunction

  function automatic logic [511:0] ramp_psum();
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = k * 256;
    return r;
  endfunction

  task automatic push_uniform(input logic [15:0] v);
    beat_t e;
    for (int b = 0; b < 4; b++) begin
      e.beat = 2'(b);
      e.data = {v, v, v, v};
      exp_q.push_back(e);
    end
  endtask

  task automatic push_ramp();
    beat_t e;
    for (int b = 0; b < 4; b++) begin
      e.beat = 2'(b);
      for (int j = 0; j < 4; j++) e.data[j*16 +: 16] = 16'(4*b + j);
      exp_q.push_back(e);
    end
  endtask

  task automatic send(input logic [511:0] v, input bit first, input bit last,
                      input bit relu, input logic [4:0] sh);
    int n = 0;
    while (!pe_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!pe_ready) check("send_timeout", 64'd0, 64'd1);
    pe_psum = v; tile_first = first; tile_last = last; relu_en = relu; out_shift = sh;
    pe_valid = 1'b1;
    @(posedge clk); #1;
    pe_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    int hs0;
    rst = 1'b1; pe_psum = '0; pe_valid = 1'b0; tile_first = 1'b0; tile_last = 1'b0;
    relu_en = 1'b0; out_shift = '0; obuf_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_pe_ready",   {63'd0, pe_ready},   64'd1);
    check("rst_obuf_valid", {63'd0, obuf_valid}, 64'd0);
    check("rst_obuf_data",  obuf_data,           64'd0);
    check("rst_obuf_beat",  {62'd0, obuf_beat},  64'd0);
    check("rst_sat_flag",   {63'd0, sat_flag},   64'd0);
    @(posedge clk); #1;

    // single tile, latency check
    push_ramp();
    send(ramp_psum(), 1, 1, 0, 5'd8);
    @(negedge clk);
    check("qnt_valid_low",  {63'd0, obuf_valid}, 64'd0);
    check("qnt_ready_low",  {63'd0, pe_ready},   64'd0);
    @(negedge clk);
    check("first_valid_t2", {63'd0, obuf_valid}, 64'd1);
    wait_drain();
    check("single_sat", {63'd0, sat_flag}, 64'd0);
    @(posedge clk); #1;

    // accumulate three partials
    push_uniform(16'd300);
    send(uniform_psum(32'd100), 1, 0, 0, 5'd0);
    send(uniform_psum(32'd100), 0, 0, 0, 5'd0);
    send(uniform_psum(32'd100), 0, 1, 0, 5'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("acc_ready_busy", {63'd0, pe_ready}, 64'd0);
    end
    @(negedge clk);
    check("acc_ready_back", {63'd0, pe_ready}, 64'd1);
    wait_drain();
    @(posedge clk); #1;

    // positive clip
    push_uniform(16'd32767);
    send(uniform_psum(32'h0010_0000), 1, 1, 0, 5'd0);
    wait_drain();
    check("clip_sat", {63'd0, sat_flag}, 64'd1);
    @(posedge clk); #1;

    // ReLU, tile_first=0 from IDLE still overwrites
    push_uniform(16'd0);
    send(uniform_psum(-32'sd5), 0, 1, 1, 5'd0);
    wait_drain();
    check("relu_sat_cleared", {63'd0, sat_flag}, 64'd0);
    @(posedge clk); #1;

    // floor shift of a negative value
    push_uniform(16'hFFFD);
    send(uniform_psum(-32'sd5), 1, 1, 0, 5'd1);
    wait_drain();
    @(posedge clk); #1;

    // backpressure with ignored pe_valid during drain
    obuf_ready = 1'b0;
    hs0 = hs_count;
    push_ramp();
    send(ramp_psum(), 1, 1, 0, 5'd8);
    @(posedge clk); #1;
    pe_psum = uniform_psum(32'd7); tile_first = 1'b1; tile_last = 1'b1; pe_valid = 1'b1;
    obuf_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
      @(posedge clk); #1;
      obuf_ready = ~obuf_ready;
    end
    pe_valid = 1'b0;
    obuf_ready = 1'b1;
    wait_drain();
    repeat (4) @(negedge clk);
    check("bp_handshakes", 64'(hs_count - hs0), 64'd4);
    @(posedge clk); #1;

    // reset while beat 2 is presented
    push_ramp();
    send(ramp_psum(), 1, 1, 0, 5'd8);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("mid_drn_beat", {62'd0, obuf_beat}, 64'd2);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_valid", {63'd0, obuf_valid}, 64'd0);
    check("post_rst_ready", {63'd0, pe_ready},   64'd1);
    @(posedge clk); #1;
    push_uniform(16'd9);
    send(uniform_psum(32'd9), 0, 1, 0, 5'd0);
    wait_drain();
    @(posedge clk); #1;

    // two's-complement wrap
    push_uniform(16'h8000);
    send(uniform_psum(32'h7FFF_FFFF), 1, 0, 0, 5'd0);
    send(uniform_psum(32'd1), 0, 1, 0, 5'd16);
    wait_drain();
    check("wrap_sat", {63'd0, sat_flag}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/output_gather_pe.md
OUTPUT_GATHER_PE -- requirements
Module: output_gather_pe

Interface
REQ-001 Parameter NUM_PE, default 16, number of PE partial-sum inputs.
REQ-002 Parameter PSUM_W, default 32, signed partial-sum width.
REQ-003 Parameter OUT_W, default 16, signed output element width.
REQ-004 Parameter LANES, default 4, output elements per buffer beat; NUM_PE SHALL be a multiple of LANES; BEATS = NUM_PE/LANES.
REQ-005 clk  in  1  single clock, all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 pe_psum  in  NUM_PE*PSUM_W  PE k partial sum at [k*PSUM_W +: PSUM_W].
REQ-008 pe_valid  in  1  pe_psum, tile_first, tile_last, relu_en and out_shift are valid.
REQ-009 pe_ready  out  1  block can accept a partial-sum vector.
REQ-010 tile_first  in  1  vector starts a new output tile (overwrite, no accumulate).
REQ-011 tile_last  in  1  vector is the final partial of the output tile.
REQ-012 relu_en  in  1  clamp negative results to zero.
REQ-013 out_shift  in  5  arithmetic right-shift amount for requantisation.
REQ-014 obuf_data  out  LANES*OUT_W  lane j at [j*OUT_W +: OUT_W].
REQ-015 obuf_beat  out  clog2(BEATS)  beat index of obuf_data.
REQ-016 obuf_valid  out  1  beat is presented to the output buffer.
REQ-017 obuf_ready  in  1  output buffer accepts the beat.
REQ-018 tile_done  out  1  one-cycle pulse when a tile has fully drained.
REQ-019 sat_flag  out  1  sticky: at least one lane clipped in the current tile.

Function
REQ-020 The FSM SHALL have states IDLE, ACC, QNT and DRN.
REQ-021 pe_ready SHALL be 1 in IDLE and ACC and 0 in QNT and DRN.
REQ-022 An accept SHALL be pe_valid & pe_ready; pe_valid while pe_ready=0 SHALL be ignored, and upstream holds its data.
REQ-023 On accept in IDLE, or on accept with tile_first=1: acc[k] <= pe_psum[k] and sat_flag <= 0.
REQ-024 On accept in ACC with tile_first=0: acc[k] <= acc[k] + pe_psum[k], PSUM_W two's-complement wrap, no saturation.
REQ-025 On accept with tile_last=0 the next state SHALL be ACC; with tile_last=1 it SHALL be QNT, and relu_en and out_shift SHALL be registered.
REQ-026 QNT SHALL last exactly one cycle and compute per lane: s = acc >>> out_shift (floor).
REQ-026a In the same cycle: if relu set and s<0 then 0; saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; result registered.
REQ-027 sat_flag SHALL be set in QNT if any lane saturated, and held until the next overwrite or reset.
REQ-028 QNT -> DRN with beat=0; obuf_valid=1 throughout DRN.
REQ-029 In DRN, obuf_data lane j SHALL be quantised result of PE beat*LANES+j, with obuf_beat=beat.
REQ-030 obuf_data and obuf_beat SHALL be stable while obuf_valid=1 and obuf_ready=0.
REQ-031 On obuf_valid & obuf_ready: beat increments; on beat=BEATS-1 the state SHALL return to IDLE.
REQ-032 tile_done SHALL pulse for one cycle, in the cycle after the final beat handshake.
REQ-033 Latency: an accept with tile_last at edge T gives QNT in cycle T+1 and the first obuf_valid in cycle T+2.
REQ-034 Minimum drain time is BEATS cycles; obuf_ready while obuf_valid=0 SHALL have no effect.
REQ-035 The outputs SHALL carry no X after reset, regardless of inputs.

Reset
REQ-036 At a rising edge with rst=1: state=IDLE, acc=0, beat=0, obuf_valid=0, obuf_data=0, obuf_beat=0, tile_done=0, sat_flag=0.
REQ-037 After reset pe_ready SHALL be 1, from the first cycle after reset.
REQ-038 Reset in any state, including mid-DRN, SHALL discard the tile without a tile_done pulse.

Verification
REQ-039 Single tile: tile_first=tile_last=1, psum[k]=k*256, shift 8, relu 0 -> beats 0..3, lane j of beat b = 4b+j, first valid at T+2, tile_done one cycle after beat 3.
REQ-040 Accumulate: three accepts of psum 100 (first, -, last), shift 0 -> every lane 300; pe_ready=0 from QNT until after the last beat.
REQ-041 Clip/ReLU: psum 0x00100000 shift 0 -> 32767 and sat_flag=1; psum -5 relu 1 -> 0; psum -5 relu 0 shift 1 -> -3.
REQ-042 Backpressure: obuf_ready toggles 1,0,1,0 -> data and beat held during stalls, 4 handshakes total; pe_valid pulses in DRN are not captured.
REQ-043 Reset mid-drain at beat 2 -> obuf_valid=0 next cycle, no tile_done; the next accept with tile_first=0 overwrites.
REQ-044 Wrap: 0x7FFFFFFF then +1, shift 16 -> acc 0x80000000, outputs -32768, sat_flag=0.
